blink_ctrl: RTL and testbench

- Sits directly downstream of the button debouncer in the Blinking_Point design.
- Consumes the debouncer's one-cycle press pulse and steps through four LED modes: OFF, SLOW blink, FAST blink, steady ON.
- Contains a free-running prescaler, a blink phase counter and a mode state machine, and drives the point LED from a register.

---
 rtl/blink_pkg.sv | 31 +++
 rtl/tick_gen.sv | 37 +++
 rtl/blink_ctrl.sv | 101 ++++++++++
 tb/tb_blink_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared mode encoding, counter widths and mode sequencing for the point-LED blink blocks.
package blink_pkg;

    localparam int PCNT_W = 16;
    localparam int HCNT_W = 8;
    localparam int ACNT_W = 16;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_OFF:  nxt = MODE_SLOW;
            MODE_SLOW: nxt = MODE_FAST;
            MODE_FAST: nxt = MODE_ON;
            default:   nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

    // Every mode except OFF starts with the LED lit.
    function automatic logic mode_led(input mode_t m);
        return (m != MODE_OFF);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: TICK pulses for one cycle every TICK_DIV clocks.
module tick_gen
    import blink_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    if (TICK_DIV < 2 || TICK_DIV > (2 ** PCNT_W)) begin : g_bad_tick_div
        $error("tick_gen: TICK_DIV out of range");
    end

    logic [PCNT_W-1:0] r_pcnt;
    logic              w_wrap;

    assign w_wrap = (r_pcnt == PCNT_LAST);

    // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pcnt <= '0;
        end else if (w_wrap) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PCNT_ONE;
        end
    end

    assign TICK = w_wrap;

endmodule

// File: rtl/blink_ctrl.sv
// Point-LED mode controller: each debounced press steps OFF->SLOW->FAST->ON and the LED blinks per mode.
// Define BLINK_AUTO_OFF_EN to compile in the idle auto-off timer.
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int SLOW_TICKS     = 100,
    parameter int FAST_TICKS     = 25,
    parameter int AUTO_OFF_TICKS = 60000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_P,
    output logic       LED,
    output logic [1:0] MODE
);

    localparam logic [HCNT_W-1:0] SLOW_LAST = HCNT_W'(SLOW_TICKS - 1);
    localparam logic [HCNT_W-1:0] FAST_LAST = HCNT_W'(FAST_TICKS - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    if (SLOW_TICKS < 1 || SLOW_TICKS > (2 ** HCNT_W) - 1) begin : g_bad_slow
        $error("blink_ctrl: SLOW_TICKS out of range");
    end
    if (FAST_TICKS < 1 || FAST_TICKS > (2 ** HCNT_W) - 1) begin : g_bad_fast
        $error("blink_ctrl: FAST_TICKS out of range");
    end
    if (AUTO_OFF_TICKS < 1 || AUTO_OFF_TICKS > (2 ** ACNT_W) - 1) begin : g_bad_auto_off
        $error("blink_ctrl: AUTO_OFF_TICKS out of range");
    end

    mode_t             r_mode;
    logic              r_led;
    logic [HCNT_W-1:0] r_hcnt;

    logic w_tick;
    logic w_blinking;
    logic w_half_done;
    logic w_expire;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK   (CLK),
        .RST_N (RST_N),
        .TICK  (w_tick)
    );

    assign w_blinking  = (r_mode == MODE_SLOW) || (r_mode == MODE_FAST);
    assign w_half_done = (r_hcnt == ((r_mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST));

`ifdef BLINK_AUTO_OFF_EN
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(AUTO_OFF_TICKS - 1);
    localparam logic [ACNT_W-1:0] ACNT_ONE  = ACNT_W'(1);

    logic [ACNT_W-1:0] r_acnt;

    assign w_expire = w_tick && (r_mode != MODE_OFF) && (r_acnt == ACNT_LAST);

    // Idle window restarts on any press and stays parked at zero while OFF.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_acnt <= '0;
        end else if (BTN_P || w_expire || (r_mode == MODE_OFF)) begin
            r_acnt <= '0;
        end else if (w_tick) begin
            r_acnt <= r_acnt + ACNT_ONE;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Priority: press beats auto-off expiry, which beats a blink tick.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_mode <= MODE_OFF;
            r_led  <= 1'b0;
            r_hcnt <= '0;
        end else if (BTN_P) begin
            r_mode <= next_mode(r_mode);
            r_led  <= mode_led(next_mode(r_mode));
            r_hcnt <= '0;
        end else if (w_expire) begin
            r_mode <= MODE_OFF;
            r_led  <= 1'b0;
            r_hcnt <= '0;
        end else if (w_tick && w_blinking) begin
            if (w_half_done) begin
                r_hcnt <= '0;
                r_led  <= ~r_led;
            end else begin
                r_hcnt <= r_hcnt + HCNT_ONE;
            end
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;

endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl with TICK_DIV=4, SLOW_TICKS=4, FAST_TICKS=1, AUTO_OFF_TICKS=8.
// Build with BLINK_AUTO_OFF_EN defined to exercise the auto-off path.
module tb_blink_ctrl;

    localparam int TICK_DIV       = 4;
    localparam int SLOW_TICKS     = 4;
    localparam int FAST_TICKS     = 1;
    localparam int AUTO_OFF_TICKS = 8;
`ifdef BLINK_AUTO_OFF_EN
    localparam int ON_WINDOW = 20;
`else
    localparam int ON_WINDOW = 200;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_p = 1'b0;
    logic       led;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pcnt = 0;

    always #5 clk = ~clk;

    blink_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .SLOW_TICKS     (SLOW_TICKS),
        .FAST_TICKS     (FAST_TICKS),
        .AUTO_OFF_TICKS (AUTO_OFF_TICKS)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .BTN_P (btn_p),
        .LED   (led),
        .MODE  (mode)
    );

    // Prescaler phase as seen by the next rising edge.
    always @(posedge clk) begin
        if (!rst_n || exp_pcnt == TICK_DIV - 1) exp_pcnt <= 0;
        else                                    exp_pcnt <= exp_pcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Edges after a press edge until the k-th tick, given the prescaler value that press edge saw.
    function automatic int tick_offset(input int p, input int k);
        int q;
        q = (p + 1) % TICK_DIV;
        return (TICK_DIV - q) + (k - 1) * TICK_DIV;
    endfunction

    task automatic press(output int p);
        p     = exp_pcnt;
        btn_p = 1'b1;
        @(negedge clk);
        btn_p = 1'b0;
    endtask

    task automatic wait_led(input logic old, input int bound, output int cycles);
        cycles = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (led !== old) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic wait_mode(input logic [1:0] old, input int bound, output int cycles);
        cycles = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (mode !== old) begin
                cycles = c;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int c;
        int found;

        // Reset held for several edges while the button pulses.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_led", led, 1'b0);
            check("rst_mode", mode, 2'd0);
            btn_p = (i == 0 || i == 2);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_mode", mode, 2'd0);
            check("idle_led", led, 1'b0);
        end

        // SLOW: first toggle on the 4th tick, then every 16 cycles.
        press(p);
        check("slow_mode", mode, 2'd1);
        check("slow_led", led, 1'b1);
        wait_led(1'b1, 40, c);
        check("slow_first_toggle", c, tick_offset(p, SLOW_TICKS));
        check("slow_first_range", (c >= 13 && c <= 16), 1'b1);
`ifndef BLINK_AUTO_OFF_EN
        wait_led(1'b0, 40, c);
        check("slow_half_period", c, 16);
`endif

        // FAST: toggles on every tick.
        press(p);
        check("fast_mode", mode, 2'd2);
        check("fast_led", led, 1'b1);
        wait_led(1'b1, 10, c);
        check("fast_first_toggle", c, tick_offset(p, FAST_TICKS));
        wait_led(1'b0, 10, c);
        check("fast_half_period_a", c, 4);
        wait_led(1'b1, 10, c);
        check("fast_half_period_b", c, 4);

        // Press lands on the tick edge with LED lit: the press wins, no toggle.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (led === 1'b1 && exp_pcnt == TICK_DIV - 1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("tick_align_found", found, 1);
        press(p);
        check("tick_press_mode", mode, 2'd3);
        check("tick_press_led", led, 1'b1);

        for (int i = 0; i < ON_WINDOW; i++) begin
            @(negedge clk);
            check("on_mode", mode, 2'd3);
            check("on_led", led, 1'b1);
        end

        press(p);
        check("off_mode", mode, 2'd0);
        check("off_led", led, 1'b0);

        // Button held two cycles counts as two presses.
        btn_p = 1'b1;
        @(negedge clk);
        check("hold_first_mode", mode, 2'd1);
        @(negedge clk);
        btn_p = 1'b0;
        check("hold_second_mode", mode, 2'd2);
        check("hold_second_led", led, 1'b1);

        // One-cycle reset mid-FAST with the LED dark.
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (led === 1'b0) begin
                found = 1;
                break;
            end
        end
        check("fast_dark_found", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_mode", mode, 2'd0);
        check("midrst_led", led, 1'b0);
        check("midrst_pcnt", dut.u_tick_gen.r_pcnt, 16'd0);
        check("midrst_hcnt", dut.r_hcnt, 8'd0);

        // Prescaler restarted from zero: press edge sees PCNT=0, first SLOW toggle 15 cycles later.
        press(p);
        check("post_rst_phase", p, 0);
        wait_led(1'b1, 40, c);
        check("post_rst_toggle", c, 15);
`ifndef BLINK_AUTO_OFF_EN
        repeat (40) @(negedge clk);
        check("slow_persists", mode, 2'd1);
`endif
        press(p);
        press(p);
        press(p);
        check("cycle_back_off", mode, 2'd0);
        check("cycle_back_led", led, 1'b0);

`ifdef BLINK_AUTO_OFF_EN
        // Untouched SLOW expires on the 8th tick after entry.
        press(p);
        check("ao_enter_mode", mode, 2'd1);
        wait_mode(2'd1, 40, c);
        check("ao_expire_cycles", c, tick_offset(p, AUTO_OFF_TICKS));
        check("ao_expire_range", (c >= 29 && c <= 32), 1'b1);
        check("ao_expire_mode", mode, 2'd0);
        check("ao_expire_led", led, 1'b0);

        // A press at cycle 20 restarts the idle window.
        press(p);
        repeat (19) @(negedge clk);
        check("ao_before_restart", mode, 2'd1);
        press(p);
        check("ao_restart_mode", mode, 2'd2);
        wait_mode(2'd2, 40, c);
        check("ao_restart_cycles", c, tick_offset(p, AUTO_OFF_TICKS));
        check("ao_restart_off", mode, 2'd0);
        check("ao_restart_led", led, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
